// File: rtl/input_debounce_edge.sv
// ============================================================================
// Module   : input_debounce_edge
// Brief    : Synchronise, debounce and edge-detect one input bit; count edges.
//            Optional glitch counter enabled by DEBOUNCE_GLITCH_COUNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module input_debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             clr_count,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] glitch_count
);

  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    PEND_HIGH = 2'd1,
    S_HIGH    = 2'd2,
    PEND_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state, w_state_n;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_n;
  logic                   w_rise_n, w_fall_n, w_level_n, w_busy_n;
  logic                   r_level, r_rise, r_fall, r_busy;
  logic [CNT_W-1:0]       r_edge_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], din};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_level <= w_level_n;
      r_rise  <= w_rise_n;
      r_fall  <= w_fall_n;
      r_busy  <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rise_n  = 1'b0;
    w_fall_n  = 1'b0;
    case (r_state)
      S_LOW: begin
        if (w_s) begin
          w_state_n = PEND_HIGH;
          w_cnt_n   = '0;
        end
      end
      PEND_HIGH: begin
        if (!w_s) begin
          w_state_n = S_LOW;
        end else if (r_cnt == c_cnt_last) begin
          w_state_n = S_HIGH;
          w_rise_n  = 1'b1;
        end else begin
          w_cnt_n = r_cnt + c_cnt_w'(1);
        end
      end
      S_HIGH: begin
        if (!w_s) begin
          w_state_n = PEND_LOW;
          w_cnt_n   = '0;
        end
      end
      PEND_LOW: begin
        if (w_s) begin
          w_state_n = S_HIGH;
        end else if (r_cnt == c_cnt_last) begin
          w_state_n = S_LOW;
          w_fall_n  = 1'b1;
        end else begin
          w_cnt_n = r_cnt + c_cnt_w'(1);
        end
      end
      default: w_state_n = S_LOW;
    endcase
    // Outputs are registered, so they are derived from the next state.
    w_level_n = (w_state_n == S_HIGH) || (w_state_n == PEND_LOW);
    w_busy_n  = (w_state_n == PEND_HIGH) || (w_state_n == PEND_LOW);
  end

  // Clear wins over a coincident edge event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_edge_count <= '0;
    else if (clr_count)            r_edge_count <= '0;
    else if (w_rise_n || w_fall_n) r_edge_count <= r_edge_count + CNT_W'(1);
  end

`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic             w_abort;
  logic [CNT_W-1:0] r_glitch_count;

  assign w_abort = ((r_state == PEND_HIGH) && !w_s) || ((r_state == PEND_LOW) && w_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_glitch_count <= '0;
    else if (clr_count)                         r_glitch_count <= '0;
    else if (w_abort && (r_glitch_count != '1)) r_glitch_count <= r_glitch_count + CNT_W'(1);
  end

  assign glitch_count = r_glitch_count;
`else
  assign glitch_count = '0;
`endif

  assign level      = r_level;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign busy       = r_busy;
  assign edge_count = r_edge_count;

endmodule

`default_nettype wire

// File: doc/input_debounce_edge.md
# input_debounce_edge

Single-bit input conditioner placed directly downstream of the registered input flop. It synchronises the registered bit into `clk`, debounces it, and emits a clean level plus one-cycle rise/fall pulses. It also keeps a running edge count for software. It is the standard consumer of any externally sourced control bit before core logic uses it.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth; legal range ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to accept a change; legal range ≥1.
- `CNT_W`, 8: width of the edge and glitch counters.

- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `din`  in  1  registered input bit (may be asynchronous to `clk`)
- `clr_count`  in  1  synchronous clear of the counters
- `level`  out  1  debounced level
- `rise`  out  1  one-cycle pulse on an accepted 0→1 change
- `fall`  out  1  one-cycle pulse on an accepted 1→0 change
- `busy`  out  1  high while the FSM is in a pending state
- `edge_count`  out  CNT_W  accepted rise+fall events, modulo 2^CNT_W
- `glitch_count`  out  CNT_W  aborted pending changes (see Configuration)

## Operation
- Synchroniser: `SYNC_STAGES` flops, all reset to 0. `s` is the last stage.
- FSM states: S_LOW, PEND_HIGH, S_HIGH, PEND_LOW. Reset state is S_LOW.
- S_LOW:
  - `s`=1 → PEND_HIGH, `cnt`←0.
- PEND_HIGH:
  - `s`=0 → S_LOW (glitch).
  - Otherwise, if `cnt`==DEBOUNCE_CYCLES-1 → S_HIGH, with `level`←1 and `rise`←1.
  - Otherwise `cnt`++.
- S_HIGH and PEND_LOW mirror S_LOW and PEND_HIGH with polarity inverted, producing `fall` and `level`←0.
- `busy` = 1 in PEND_HIGH and PEND_LOW.
- `cnt`:
  - Width is clog2(DEBOUNCE_CYCLES), minimum 1.
  - It is never compared beyond DEBOUNCE_CYCLES-1.
- `edge_count`:
  - Increments by 1 in the cycle `rise` or `fall` asserts.
  - Wraps from all-ones to 0.
- `clr_count`=1 sets `edge_count` (and `glitch_count`) to 0 on the next edge. Clear has priority: an edge event in the same cycle is not counted.
- `rise` and `fall` are mutually exclusive and never asserted on consecutive cycles.
- Reset values (all outputs registered): `level`=0, `rise`=0, `fall`=0, `busy`=0, `edge_count`=0, `glitch_count`=0.
- Reset mid-operation:
  - Aborts any pending state and returns to S_LOW.
  - No pulse is generated by the reset itself.
  - If `din`=1 is held through reset release, a normal `rise` follows after full latency.

## Timing
- Latency: edge 1 is the first edge sampling the new `din`. `level`/`rise` update on edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Defaults give edge 7.
- `rise` and `fall` are high for exactly one cycle, coincident with the first cycle of the new `level`.
- A `s` pulse shorter than DEBOUNCE_CYCLES+1 cycles produces no `level` change and no pulse.
- Minimum spacing between accepted events is DEBOUNCE_CYCLES+1 cycles.
- `busy` rises one cycle after `s` changes and drops in the cycle the change is accepted or aborted.

## Configuration
- `DEBOUNCE_GLITCH_COUNT_EN`:
  - Defined: `glitch_count` increments on every PEND→stable-state abort. It saturates at 2^CNT_W-1 (no wrap) and is cleared by `clr_count` or `reset`.
  - Undefined: `glitch_count` is constant 0 and the counter logic is absent.
  - The port exists in both builds.

## Test plan
- Reset with `din`=0, release, hold 20 cycles → `level`=0, no pulses, `edge_count`=0, `busy`=0.
- Defaults: `din` 0→1 held → `rise` high for one cycle on edge 7, `level`=1 from edge 7, `edge_count`=1. Then `din` 1→0 → `fall` on edge 7 after that change, `edge_count`=2.
- Defaults: `din` high for 3 cycles then low → `level` stays 0, no `rise`, `busy` pulses. `glitch_count`=1 with `DEBOUNCE_GLITCH_COUNT_EN`, 0 without.
- CNT_W=2, four full toggles → `edge_count` sequence 1,2,3,0,1…; assert `clr_count` in the cycle of a `rise` → `edge_count`=0.
- Assert `reset` while in PEND_HIGH (cnt=2) with `din`=1 held → outputs 0 immediately. After release, `rise` arrives on edge 7 after the first post-reset edge.
- DEBOUNCE_CYCLES=1, SYNC_STAGES=3: `din` 0→1 → `rise` on edge 5; a 1-cycle `din` low pulse → rejected.
